// File: rtl/bcd_to_binary_16bit_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The requester drives start/bcd_in; the converter answers with busy/done/err/binary_out.
interface bcd_to_binary_16bit_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      binary_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, binary_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, binary_out
  );
endinterface

// File: rtl/bcd_to_binary_16bit_seq.sv
// Sequential reverse double-dabble: packed BCD in, binary out, one
// shift-and-correct step per clock. Invalid digits (>9) are rejected
// immediately with done+err and no iterations.
module bcd_to_binary_16bit_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_to_binary_16bit_seq_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_reg;
  logic [W-1:0]     sr_bcd;
  logic [BIN_W-1:0] sr_bin;
  logic [CNT_W-1:0] cnt;
  logic             done_reg;
  logic             err_reg;
  logic [BIN_W-1:0] out_reg;

  logic [DIGITS-1:0] digit_bad;
  logic              any_bad;
  logic [W-1:0]      shifted_bcd;
  logic [W-1:0]      bcd_next;
  logic [BIN_W-1:0]  bin_next;

  // The bit leaving the BCD register's LSB enters the binary register's MSB.
  assign shifted_bcd = {1'b0, sr_bcd[W-1:1]};
  assign bin_next    = {sr_bcd[0], sr_bin[BIN_W-1:1]};

  // Per-digit validation of the input and per-digit correction after the shift;
  // each digit is corrected independently with no borrow between digits.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
    assign bcd_next[4*gi +: 4] = (shifted_bcd[4*gi +: 4] >= 4'd8)
                               ? (shifted_bcd[4*gi +: 4] - 4'd3)
                               : shifted_bcd[4*gi +: 4];
  end

  assign any_bad = |digit_bad;

  assign bus.busy       = (state_reg == S_SHIFT);
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.binary_out = out_reg;

  // Handshake FSM plus the shift/correct datapath; done/err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      sr_bcd    <= '0;
      sr_bin    <= '0;
      cnt       <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      out_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if (any_bad) begin
              // Reject without converting; result reads as zero.
              done_reg <= 1'b1;
              err_reg  <= 1'b1;
              out_reg  <= '0;
            end else begin
              sr_bcd    <= bus.bcd_in;
              sr_bin    <= '0;
              cnt       <= '0;
              state_reg <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          sr_bcd <= bcd_next;
          sr_bin <= bin_next;
          if (cnt == CNT_LAST) begin
            out_reg   <= bin_next;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_16bit_seq.sv
// Self-checking bench: cycle-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_to_binary_16bit_seq;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bcd_to_binary_16bit_seq_if #(.DIGITS(4), .BIN_W(16)) bus ();

  bcd_to_binary_16bit_seq #(.DIGITS(4), .BIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic int bcd_val(input logic [15:0] b);
    int v = 0;
    int scale = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'((b >> (4 * i)) & 16'hF) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [15:0] b);
    bit r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (((b >> (4 * i)) & 16'hF) > 16'd9) r = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A conversion occupies 16 edges after acceptance; a rejected input
  // answers on the accepting edge itself.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [15:0] m_out  = 16'h0;
  int          m_rem  = 0;
  logic [15:0] m_pend = 16'h0;
  logic [15:0] m_pend_bcd = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_out  <= 16'h0;
      m_rem  <= 0;
    end else begin
      automatic int rem = m_rem;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          m_done <= 1'b1;
          m_out  <= m_pend;
          $display("txn bcd=%h expect=%h err=0", m_pend_bcd, m_pend);
        end
      end else if (bus.start) begin
        if (bcd_bad(bus.bcd_in)) begin
          m_done <= 1'b1;
          m_err  <= 1'b1;
          m_out  <= 16'h0;
          $display("txn bcd=%h expect=0000 err=1", bus.bcd_in);
        end else begin
          rem = 16;
          m_pend     <= 16'(bcd_val(bus.bcd_in));
          m_pend_bcd <= bus.bcd_in;
        end
      end
      m_rem  <= rem;
      m_busy <= (rem > 0);
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy",       32'(bus.busy),       32'(m_busy));
    check("done",       32'(bus.done),       32'(m_done));
    check("err",        32'(bus.err),        32'(m_err));
    check("binary_out", 32'(bus.binary_out), 32'(m_out));
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_one(input logic [15:0] bcd, input logic [15:0] exp_out,
                         input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency",  32'(lat),            32'(exp_lat));
    check("lit_out",  32'(bus.binary_out), 32'(exp_out));
    check("lit_err",  32'(bus.err),        32'(exp_err));
    if (exp_err) check("lit_busy_low", 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      if ($urandom_range(0, 15) == 0) d = 4'(10 + $urandom_range(0, 5));
      else                            d = 4'($urandom_range(0, 9));
      r = r | (16'(d) << (4 * i));
    end
    return r;
  endfunction

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    int pos[$];
    bus.start  = 1'b0;
    bus.bcd_in = 16'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out",  32'(bus.binary_out), 32'd0);
    rst_n = 1'b1;

    // Max value, then hold check.
    run_one(16'h9999, 16'h270F, 1'b0, 16);
    @(negedge clk);
    check("hold_done", 32'(bus.done), 32'd0);
    check("hold_out",  32'(bus.binary_out), 32'h270F);

    run_one(16'h2024, 16'h07E8, 1'b0, 16);
    run_one(16'h0000, 16'h0000, 1'b0, 16);
    run_one(16'h0001, 16'h0001, 1'b0, 16);
    run_one(16'h12A4, 16'h0000, 1'b1, 0);

    // Start ignored while busy; bcd_in changes after acceptance are ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0365;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h1234;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 16'hFFFF;
    ndone = 0;
    for (int k = 0; k < 11 && !bus.done; k++) @(negedge clk);
    check("ovl_done", 32'(bus.done), 32'd1);
    check("ovl_out",  32'(bus.binary_out), 32'h016D);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("ovl_no_second", 32'(ndone), 32'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h5000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_err",  32'(bus.err),  32'd0);
    check("abort_out",  32'(bus.binary_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_one(16'h0059, 16'h003B, 1'b0, 16);

    // Start held high: back-to-back accepts every 17 edges.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0100;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      if (bus.done) begin
        pos.push_back(k);
        check("held_out", 32'(bus.binary_out), 32'h0064);
      end
    end
    bus.start = 1'b0;
    check("held_count", 32'(pos.size()), 32'd3);
    if (pos.size() == 3) begin
      check("held_pos0", 32'(pos[0]), 32'd16);
      check("held_pos1", 32'(pos[1]), 32'd33);
      check("held_pos2", 32'(pos[2]), 32'd50);
    end
    repeat (20) @(negedge clk);

    // Randomized directed transactions with full latency checks.
    for (int t = 0; t < 60; t++) begin
      logic [15:0] b;
      b = rand_bcd();
      if (bcd_bad(b)) run_one(b, 16'h0000, 1'b1, 0);
      else            run_one(b, 16'(bcd_val(b)), 1'b0, 16);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Free-running random start/bcd_in noise; the model covers every cycle.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.bcd_in = rand_bcd();
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
